// File: rtl/controle_divisao.sv
// Multi-cycle Goldschmidt divider sequencer that time-shares one WIDTH x WIDTH multiplier.
// Define GSD_ARREDONDA_EN to round half up on every product slice instead of truncating.
module controle_divisao #(
   parameter int WIDTH      = 20,
   parameter int FRAC       = 12,
   parameter int ITER       = 5,
   parameter int SHIFT_INIT = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inicio,
   output logic             pronto,
   input  logic [WIDTH-1:0] dividendo,
   input  logic [WIDTH-1:0] divisor,
   input  logic [WIDTH-1:0] fator_inicial,
   output logic [WIDTH-1:0] quociente,
   output logic             valido,
   input  logic             aceita,
   output logic             ocupado,
   output logic             erro_div0,
   output logic [1:0]       dbg_estado
);

   localparam int CW = $clog2(ITER) + 1;
   localparam logic [WIDTH-1:0]   TWO     = WIDTH'(1) << (FRAC + 1);
   localparam logic [CW-1:0]      CNT_ULT = CW'(ITER - 1);
`ifdef GSD_ARREDONDA_EN
   localparam logic [2*WIDTH-1:0] ARRED   = (2*WIDTH)'(1) << (FRAC - 1);
`else
   localparam logic [2*WIDTH-1:0] ARRED   = '0;
`endif

   typedef enum logic [1:0] {
      OCIOSO = 2'd0,
      MUL_N  = 2'd1,
      MUL_D  = 2'd2,
      FIM    = 2'd3
   } estado_t;

   estado_t          r_estado, w_estado_nxt;
   logic [WIDTH-1:0] r_n, r_d, r_f, r_quoc;
   logic [WIDTH-1:0] w_n_nxt, w_d_nxt, w_f_nxt, w_quoc_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_valido, w_valido_nxt;
   logic             r_erro, w_erro_nxt;

   // Single shared multiplier: F times N in MUL_N, F times D otherwise.
   logic [WIDTH-1:0]   w_op;
   logic [2*WIDTH-1:0] w_prod, w_prod_aj;
   logic [WIDTH-1:0]   w_slice;
   logic [WIDTH-1:0]   w_f_inicial;
   logic               w_unused_bits;

   assign w_op          = (r_estado == MUL_N) ? r_n : r_d;
   assign w_prod        = {{WIDTH{1'b0}}, r_f} * {{WIDTH{1'b0}}, w_op};
   assign w_prod_aj     = w_prod + ARRED;
   assign w_slice       = w_prod_aj[WIDTH+FRAC-1:FRAC];
   assign w_unused_bits = ^{w_prod_aj[2*WIDTH-1:WIDTH+FRAC], w_prod_aj[FRAC-1:0]};
   assign w_f_inicial   = (fator_inicial != '0) ? fator_inicial : (divisor >> SHIFT_INIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado <= OCIOSO;
         r_n      <= '0;
         r_d      <= '0;
         r_f      <= '0;
         r_cnt    <= '0;
         r_quoc   <= '0;
         r_valido <= 1'b0;
         r_erro   <= 1'b0;
      end else begin
         r_estado <= w_estado_nxt;
         r_n      <= w_n_nxt;
         r_d      <= w_d_nxt;
         r_f      <= w_f_nxt;
         r_cnt    <= w_cnt_nxt;
         r_quoc   <= w_quoc_nxt;
         r_valido <= w_valido_nxt;
         r_erro   <= w_erro_nxt;
      end
   end

   // Handshakes: a request is taken on an edge with inicio && pronto; a result
   // is held while valido && !aceita and retired on an edge with valido && aceita.
   always_comb begin
      w_estado_nxt = r_estado;
      w_n_nxt      = r_n;
      w_d_nxt      = r_d;
      w_f_nxt      = r_f;
      w_cnt_nxt    = r_cnt;
      w_quoc_nxt   = r_quoc;
      w_valido_nxt = r_valido;
      w_erro_nxt   = r_erro;
      case (r_estado)
         OCIOSO: begin
            if (inicio) begin
               if (divisor != '0) begin
                  w_n_nxt      = dividendo;
                  w_d_nxt      = divisor;
                  w_f_nxt      = w_f_inicial;
                  w_cnt_nxt    = '0;
                  w_estado_nxt = MUL_N;
               end else begin
                  w_quoc_nxt   = '1;
                  w_erro_nxt   = 1'b1;
                  w_valido_nxt = 1'b1;
                  w_estado_nxt = FIM;
               end
            end
         end
         MUL_N: begin
            w_n_nxt      = w_slice;
            w_estado_nxt = MUL_D;
         end
         MUL_D: begin
            // F = 2 - D wraps modulo 2^WIDTH, matching the unsaturated slice.
            w_d_nxt = w_slice;
            w_f_nxt = TWO - w_slice;
            if (r_cnt == CNT_ULT) begin
               w_quoc_nxt   = r_n;
               w_valido_nxt = 1'b1;
               w_erro_nxt   = 1'b0;
               w_estado_nxt = FIM;
            end else begin
               w_cnt_nxt    = r_cnt + CW'(1);
               w_estado_nxt = MUL_N;
            end
         end
         FIM: begin
            if (aceita) begin
               w_valido_nxt = 1'b0;
               w_estado_nxt = OCIOSO;
            end
         end
         default: w_estado_nxt = OCIOSO;
      endcase
   end

   assign pronto     = (r_estado == OCIOSO);
   assign ocupado    = (r_estado == MUL_N) || (r_estado == MUL_D);
   assign quociente  = r_quoc;
   assign valido     = r_valido;
   assign erro_div0  = r_erro;
   assign dbg_estado = r_estado;

endmodule

// File: tb/tb_controle_divisao.sv
// Directed bench for controle_divisao: hand-computed quotients, latency, div-by-zero,
// back-pressure and mid-operation reset.
module tb_controle_divisao;

   localparam int W = 20;

   logic         clk = 1'b0;
   logic         rst;
   logic         inicio;
   logic         pronto;
   logic [W-1:0] dividendo;
   logic [W-1:0] divisor;
   logic [W-1:0] fator_inicial;
   logic [W-1:0] quociente;
   logic         valido;
   logic         aceita;
   logic         ocupado;
   logic         erro_div0;
   logic [1:0]   dbg_estado;

   int n_testes = 0;
   int n_falhas = 0;

   controle_divisao dut (
      .clk           (clk),
      .rst           (rst),
      .inicio        (inicio),
      .pronto        (pronto),
      .dividendo     (dividendo),
      .divisor       (divisor),
      .fator_inicial (fator_inicial),
      .quociente     (quociente),
      .valido        (valido),
      .aceita        (aceita),
      .ocupado       (ocupado),
      .erro_div0     (erro_div0),
      .dbg_estado    (dbg_estado)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_testes++;
      if (obs !== exp) begin
         n_falhas++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for pronto, present one request for exactly one edge.
   task automatic envia(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] f);
      int k = 0;
      while (!pronto && k < 50) begin
         tick();
         k++;
      end
      check("pronto_antes_envio", pronto, 1);
      dividendo     = a;
      divisor       = b;
      fator_inicial = f;
      inicio        = 1'b1;
      tick();
      inicio        = 1'b0;
   endtask

   // lat counts edges after the accept edge until valido is seen.
   task automatic espera(input string tag, input int lat_exp, input int ocup_exp,
                         input logic [W-1:0] q_exp, input logic e_exp);
      int lat = 0;
      int ocup = 0;
      while (!valido && lat < 50) begin
         if (ocupado) ocup++;
         tick();
         lat++;
      end
      check({tag, "_latencia"}, lat, lat_exp);
      check({tag, "_ocupado"}, ocup, ocup_exp);
      check({tag, "_quociente"}, quociente, q_exp);
      check({tag, "_erro"}, erro_div0, e_exp);
   endtask

   task automatic consome(input string tag);
      aceita = 1'b1;
      tick();
      aceita = 1'b0;
      check({tag, "_valido_baixo"}, valido, 0);
      check({tag, "_pronto_alto"}, pronto, 1);
   endtask

   initial begin
      logic [W-1:0] q_arred;
      int           n_val;
`ifdef GSD_ARREDONDA_EN
      q_arred = 20'h00001;
`else
      q_arred = 20'h00000;
`endif
      rst = 1'b1; inicio = 1'b0; aceita = 1'b0;
      dividendo = '0; divisor = '0; fator_inicial = '0;
      tick();
      tick();
      check("reset_pronto", pronto, 1);
      check("reset_valido", valido, 0);
      check("reset_ocupado", ocupado, 0);
      check("reset_erro", erro_div0, 0);
      check("reset_quociente", quociente, 20'h00000);
      rst = 1'b0;
      tick();

      // 6.0 / 1.0 with F0 = 1.0
      envia(20'h06000, 20'h01000, 20'h01000);
      espera("seis_por_um", 10, 10, 20'h06000, 1'b0);
      consome("seis_por_um");

      // 3.0 / 0.5 with F0 = 2.0
      envia(20'h03000, 20'h00800, 20'h02000);
      espera("tres_por_meio", 10, 10, 20'h06000, 1'b0);
      consome("tres_por_meio");

      // F0 = 0 picks divisor >> 7 = 1.0; D wraps to 0 and F settles at 2.0
      envia(20'h01000, 20'h80000, 20'h00000);
      espera("fator_padrao", 10, 10, 20'h10000, 1'b0);
      consome("fator_padrao");

      // Zero divisor: immediate error result, never busy
      envia(20'h01234, 20'h00000, 20'h01000);
      espera("div_zero", 0, 0, 20'hFFFFF, 1'b1);
      check("div_zero_ocupado", ocupado, 0);
      consome("div_zero");

      // 1 LSB * 0.5: truncates to 0, rounds to 1
      envia(20'h00001, 20'h02000, 20'h00800);
      espera("arredonda", 10, 10, q_arred, 1'b0);
      consome("arredonda");

      // Back-pressure with inicio held high during computation and FIM
      envia(20'h03000, 20'h00800, 20'h02000);
      dividendo = 20'h01234; divisor = 20'h01000; fator_inicial = 20'h01000;
      inicio = 1'b1;
      espera("pressao", 10, 10, 20'h06000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("pressao_valido", valido, 1);
         check("pressao_quociente", quociente, 20'h06000);
         check("pressao_pronto", pronto, 0);
      end
      inicio = 1'b0;
      consome("pressao");
      tick();
      check("pressao_sem_aceite", ocupado, 0);

      // Reset 4 edges after accept discards the division
      envia(20'h06000, 20'h01000, 20'h01000);
      repeat (3) tick();
      check("meio_ocupado", ocupado, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_meio_pronto", pronto, 1);
      check("rst_meio_valido", valido, 0);
      check("rst_meio_ocupado", ocupado, 0);
      check("rst_meio_quociente", quociente, 20'h00000);
      n_val = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (valido) n_val++;
      end
      check("rst_meio_sem_valido", n_val, 0);
      envia(20'h03000, 20'h01000, 20'h01000);
      espera("pos_reset", 10, 10, 20'h03000, 1'b0);
      consome("pos_reset");

      $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
      $finish;
   end

endmodule

// File: doc/controle_divisao.md
Name: controle_divisao

Overview:
- Multi-cycle sequencer for Goldschmidt division on unsigned fixed-point operands (Q8.12 by default).
- Time-shares one WIDTH x WIDTH multiplier across the N = F*N, D = F*D and F = 2 - D recurrence, replacing the fully unrolled combinational divider.
- Sits between a requester (inicio/pronto handshake) and a consumer (valido/aceita handshake).

Parameters:
- WIDTH, 20, operand/result width in bits.
- FRAC, 12, fractional bits; constant 2.0 = 1 << (FRAC+1).
- ITER, 5, Goldschmidt iterations per division (>=1).
- SHIFT_INIT, 7, right shift of divisor used as initial factor when fator_inicial == 0.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- inicio  in  1  request valid.
- pronto  out  1  block can accept a request.
- dividendo  in  WIDTH  numerator, sampled on accept.
- divisor  in  WIDTH  denominator, sampled on accept.
- fator_inicial  in  WIDTH  initial factor F0, sampled on accept; 0 selects divisor >> SHIFT_INIT.
- quociente  out  WIDTH  result, registered.
- valido  out  1  result valid.
- aceita  in  1  consumer takes result.
- ocupado  out  1  computation in progress.
- erro_div0  out  1  result came from a zero divisor; qualified by valido.

Behaviour:
- Reset (any state, including mid-operation): state OCIOSO, pronto=1, valido=0, ocupado=0, erro_div0=0, quociente=0, internal N/D/F/counter=0. Any in-flight division is discarded.
- Accept: an edge with inicio=1 and pronto=1. pronto=1 only in OCIOSO; inicio is ignored in all other states.
- OCIOSO, on accept with divisor != 0:
  - N<=dividendo, D<=divisor, F<=(fator_inicial!=0 ? fator_inicial : divisor>>SHIFT_INIT), cnt<=0.
  - Go to MUL_N.
- OCIOSO, on accept with divisor == 0:
  - quociente<={WIDTH{1}}, erro_div0<=1, valido<=1.
  - Go to FIM; valido is visible 1 cycle after accept.
- MUL_N: N <= slice(F*N); go to MUL_D.
- MUL_D:
  - p = slice(F*D); D<=p; F<=TWO-p (mod 2^WIDTH).
  - If cnt==ITER-1: quociente<=N, valido<=1, erro_div0<=0, go to FIM.
  - Else cnt<=cnt+1, go to MUL_N.
- FIM: quociente, erro_div0 and valido held stable while aceita=0. On aceita=1: valido<=0, go to OCIOSO; pronto rises the cycle after.
- ocupado=1 in MUL_N and MUL_D only.
- Latency: valido rises exactly 2*ITER edges after the accept edge (10 at defaults).
- Multiplier: exactly one instance, operand mux selects N or D. Full product is 2*WIDTH bits.
- slice(x) = x[WIDTH+FRAC-1:FRAC]; upper bits are discarded (wrap, no saturation).
- cnt width = clog2(ITER)+1.

Optional Feature:
- Macro: GSD_ARREDONDA_EN.
- Defined: slice adds 1 << (FRAC-1) to the full product before extraction (round half up) in both MUL_N and MUL_D, including the product feeding F.
- Undefined: plain truncation.
- Latency and handshake are identical either way.

Test Plan:
- Reset: rst=1 for 2 cycles -> pronto=1, valido=0, ocupado=0, erro_div0=0, quociente=0x00000.
- dividendo=0x06000 (6.0), divisor=0x01000 (1.0), fator_inicial=0x01000 -> ocupado=1 for 10 cycles; valido 10 edges after accept; quociente=0x06000, erro_div0=0.
- dividendo=0x03000 (3.0), divisor=0x00800 (0.5), fator_inicial=0x02000 -> quociente=0x06000 after 10 cycles.
- divisor=0x00000, dividendo=0x01234 -> valido 1 cycle after accept, quociente=0xFFFFF, erro_div0=1; ocupado never asserts.
- Back-pressure: hold aceita=0 for 5 cycles after valido and pulse inicio during computation and FIM -> result held, no new accept. aceita=1 -> valido=0 next edge, pronto=1.
- Two cases:
  - rst pulsed 4 cycles after accept -> next cycle pronto=1, valido stays 0, later request computes correctly.
  - dividendo=0x00001, divisor=0x02000, fator_inicial=0x00800 -> quociente=0x00000 without GSD_ARREDONDA_EN, 0x00001 with it.
